// File: rtl/line_cmd_queue.sv
// rtl/line_cmd_queue.sv - FIFO-buffered line command dispatcher for the line drawing engine
// Ports:
//   clk, reset_n                       clock, asynchronous active-low reset
//   cmd_valid/cmd_ready, cmd_x0..y1    command push side
//   cmd_clear                          flush queued commands and overflow flag
//   line_x0..y1, line_reset/start      engine coordinates and control
//   line_finish                        engine done level
//   busy, line_done, fifo_count,       status back to software
//   lines_done_cnt, overflow
module line_cmd_queue #(
  parameter int COORD_W      = 13,
  parameter int DEPTH        = 8,
  parameter int ADDR_W       = 3,
  parameter int RESET_CYCLES = 2
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [COORD_W-1:0] cmd_x0,
  input  logic [COORD_W-1:0] cmd_y0,
  input  logic [COORD_W-1:0] cmd_x1,
  input  logic [COORD_W-1:0] cmd_y1,
  input  logic               cmd_clear,
  output logic [COORD_W-1:0] line_x0,
  output logic [COORD_W-1:0] line_y0,
  output logic [COORD_W-1:0] line_x1,
  output logic [COORD_W-1:0] line_y1,
  output logic               line_reset,
  output logic               line_start,
  input  logic               line_finish,
  output logic               busy,
  output logic               line_done,
  output logic [ADDR_W:0]    fifo_count,
  output logic [15:0]        lines_done_cnt,
  output logic               overflow
);

  localparam int CMD_W = 4 * COORD_W;
  localparam int RC_W  = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);
  localparam logic [RC_W-1:0] RC_LOAD = RC_W'(RESET_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, RST, START} state_t;

  state_t              state_q, state_d;
  logic [CMD_W-1:0]    mem_q [DEPTH];
  logic [ADDR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]     count_q, count_d;
  logic                overflow_q, overflow_d;
  logic [CMD_W-1:0]    line_q, line_d;
  logic                line_reset_q, line_reset_d;
  logic                line_start_q, line_start_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic [15:0]         done_cnt_q, done_cnt_d;
  logic [RC_W-1:0]     rc_q, rc_d;
  logic                push;
  logic                pop;

  // Ready comes from the registered count only, so a full FIFO never
  // accepts a write even when the dispatcher pops in the same cycle.
  assign cmd_ready = (count_q < DEPTH_C);
  assign push      = cmd_valid & cmd_ready & ~cmd_clear;
  assign pop       = (state_q == IDLE) && (count_q != '0);

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    if (cmd_valid && !cmd_ready) overflow_d = 1'b1;
    if (cmd_clear) begin
      // Clear wins over both push and the overflow set; a popped entry
      // has already been captured into line_q this edge.
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
      overflow_d = 1'b0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + ADDR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + ADDR_W'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + (ADDR_W+1)'(1);
        2'b01:   count_d = count_q - (ADDR_W+1)'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {cmd_x0, cmd_y0, cmd_x1, cmd_y1};
  end

  always_comb begin
    state_d      = state_q;
    line_d       = line_q;
    line_reset_d = line_reset_q;
    line_start_d = line_start_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    done_cnt_d   = done_cnt_q;
    rc_d         = rc_q;
    case (state_q)
      IDLE: begin
        line_reset_d = 1'b0;
        line_start_d = 1'b0;
        busy_d       = 1'b0;
        if (pop) begin
          line_d       = mem_q[rd_ptr_q];
          line_reset_d = 1'b1;
          busy_d       = 1'b1;
          rc_d         = RC_LOAD;
          state_d      = RST;
        end
      end
      RST: begin
        // line_finish is not looked at here: the engine reset clears any
        // finish level left over from the previous line.
        if (rc_q == '0) begin
          line_reset_d = 1'b0;
          line_start_d = 1'b1;
          state_d      = START;
        end else begin
          rc_d = rc_q - RC_W'(1);
        end
      end
      START: begin
        if (line_finish) begin
          line_start_d = 1'b0;
          busy_d       = 1'b0;
          done_d       = 1'b1;
          done_cnt_d   = done_cnt_q + 16'd1;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      overflow_q   <= 1'b0;
      line_q       <= '0;
      line_reset_q <= 1'b1;
      line_start_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      done_cnt_q   <= '0;
      rc_q         <= '0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      overflow_q   <= overflow_d;
      line_q       <= line_d;
      line_reset_q <= line_reset_d;
      line_start_q <= line_start_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      done_cnt_q   <= done_cnt_d;
      rc_q         <= rc_d;
    end
  end

  assign {line_x0, line_y0, line_x1, line_y1} = line_q;
  assign line_reset     = line_reset_q;
  assign line_start     = line_start_q;
  assign busy           = busy_q;
  assign line_done      = done_q;
  assign fifo_count     = count_q;
  assign lines_done_cnt = done_cnt_q;
  assign overflow       = overflow_q;

endmodule

// File: tb/tb_line_cmd_queue.sv
// tb/tb_line_cmd_queue.sv - self-checking bench for line_cmd_queue
module tb_line_cmd_queue;

  localparam int COORD_W = 13;
  localparam int DEPTH   = 8;
  localparam int ADDR_W  = 3;
  localparam int RC      = 2;

  logic               clk = 1'b0;
  logic               reset_n = 1'b1;
  logic               cmd_valid = 1'b0;
  logic               cmd_ready;
  logic [COORD_W-1:0] cmd_x0 = '0, cmd_y0 = '0, cmd_x1 = '0, cmd_y1 = '0;
  logic               cmd_clear = 1'b0;
  logic [COORD_W-1:0] line_x0, line_y0, line_x1, line_y1;
  logic               line_reset, line_start;
  logic               line_finish = 1'b0;
  logic               busy, line_done;
  logic [ADDR_W:0]    fifo_count;
  logic [15:0]        lines_done_cnt;
  logic               overflow;

  line_cmd_queue #(.COORD_W(COORD_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .RESET_CYCLES(RC)) dut (
    .clk(clk), .reset_n(reset_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_x0(cmd_x0), .cmd_y0(cmd_y0), .cmd_x1(cmd_x1), .cmd_y1(cmd_y1),
    .cmd_clear(cmd_clear),
    .line_x0(line_x0), .line_y0(line_y0), .line_x1(line_x1), .line_y1(line_y1),
    .line_reset(line_reset), .line_start(line_start), .line_finish(line_finish),
    .busy(busy), .line_done(line_done), .fifo_count(fifo_count),
    .lines_done_cnt(lines_done_cnt), .overflow(overflow)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Behavioural model: a queue of commands plus the in-flight command and
  // the number of edges since it was popped.
  typedef struct packed {
    logic [COORD_W-1:0] x0;
    logic [COORD_W-1:0] y0;
    logic [COORD_W-1:0] x1;
    logic [COORD_W-1:0] y1;
  } cmd_t;

  cmd_t        mq[$];
  cmd_t        m_cur = '0;
  bit          m_inflight = 1'b0;
  bit          m_done = 1'b0;
  bit          m_ovf = 1'b0;
  bit          m_rst_hold = 1'b1;
  int          m_age = 0;
  int          m_pre = 0;
  logic [15:0] m_cnt = '0;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mq.delete();
      m_cur = '0; m_inflight = 1'b0; m_done = 1'b0; m_ovf = 1'b0;
      m_rst_hold = 1'b1; m_age = 0; m_cnt = '0;
    end else begin
      m_pre = mq.size();
      m_rst_hold = 1'b0;
      m_done = 1'b0;
      if (m_inflight) begin
        if (m_age >= RC && line_finish) begin
          m_inflight = 1'b0; m_done = 1'b1; m_cnt = m_cnt + 16'd1;
        end else if (m_age < RC) begin
          m_age++;
        end
      end else if (m_pre > 0) begin
        m_cur = mq.pop_front(); m_inflight = 1'b1; m_age = 0;
      end
      if (cmd_clear) begin
        mq.delete(); m_ovf = 1'b0;
      end else if (cmd_valid) begin
        if (m_pre < DEPTH) mq.push_back(cmd_t'({cmd_x0, cmd_y0, cmd_x1, cmd_y1}));
        else m_ovf = 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    check("cmp_ready",  32'(cmd_ready),      32'(mq.size() < DEPTH));
    check("cmp_count",  32'(fifo_count),     32'(mq.size()));
    check("cmp_busy",   32'(busy),           32'(m_inflight));
    check("cmp_reset",  32'(line_reset),     32'(m_rst_hold || (m_inflight && m_age < RC)));
    check("cmp_start",  32'(line_start),     32'(m_inflight && m_age >= RC));
    check("cmp_done",   32'(line_done),      32'(m_done));
    check("cmp_cnt",    32'(lines_done_cnt), 32'(m_cnt));
    check("cmp_ovf",    32'(overflow),       32'(m_ovf));
    check("cmp_x0",     32'(line_x0),        32'(m_cur.x0));
    check("cmp_y0",     32'(line_y0),        32'(m_cur.y0));
    check("cmp_x1",     32'(line_x1),        32'(m_cur.x1));
    check("cmp_y1",     32'(line_y1),        32'(m_cur.y1));
  end

  // Optional engine responder: raises finish after eng_delay START cycles.
  bit auto_eng = 1'b0;
  int eng_delay = 4;
  int start_run = 0;

  task automatic step();
    @(posedge clk);
    #2;
    if (auto_eng) begin
      if (line_start) begin
        start_run++;
        if (start_run >= eng_delay) line_finish = 1'b1;
      end else begin
        start_run = 0;
        line_finish = 1'b0;
      end
    end
  endtask

  task automatic set_cmd(input int x0, input int y0, input int x1, input int y1);
    cmd_valid = 1'b1;
    cmd_x0 = 13'(x0); cmd_y0 = 13'(y0); cmd_x1 = 13'(x1); cmd_y1 = 13'(y1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  logic [COORD_W-1:0] disp[$];
  int rlens[$];
  int gaps[$];
  int rrun, gap, ndone;
  bit prev_busy, prev_reset;

  initial begin
    // Reset state
    #1 reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    check("rst_line_reset", 32'(line_reset), 32'd1);
    check("rst_busy",       32'(busy),       32'd0);
    check("rst_count",      32'(fifo_count), 32'd0);
    check("rst_start",      32'(line_start), 32'd0);
    check("rst_cnt",        32'(lines_done_cnt), 32'd0);
    reset_n = 1'b1;
    step();
    check("rst_ready", 32'(cmd_ready),  32'd1);
    check("rst_idle",  32'(line_reset), 32'd0);

    // Single line
    set_cmd(10, 20, 300, 200);
    step(); cmd_valid = 1'b0;
    check("t1_count_e0", 32'(fifo_count), 32'd1);
    step();
    check("t1_reset_e1", 32'(line_reset), 32'd1);
    check("t1_x0",       32'(line_x0),    32'd10);
    check("t1_y1",       32'(line_y1),    32'd200);
    check("t1_busy",     32'(busy),       32'd1);
    step();
    check("t1_reset_e2", 32'(line_reset), 32'd1);
    check("t1_start_e2", 32'(line_start), 32'd0);
    step();
    check("t1_reset_e3", 32'(line_reset), 32'd0);
    check("t1_start_e3", 32'(line_start), 32'd1);
    repeat (4) step();
    check("t1_start_hold", 32'(line_start), 32'd1);
    line_finish = 1'b1;
    step();
    line_finish = 1'b0;
    check("t1_start_off", 32'(line_start),     32'd0);
    check("t1_done",      32'(line_done),      32'd1);
    check("t1_cnt",       32'(lines_done_cnt), 32'd1);
    check("t1_busy_off",  32'(busy),           32'd0);
    step();
    check("t1_done_pulse", 32'(line_done), 32'd0);

    // Fill and overflow
    for (int i = 0; i < 10; i++) begin
      set_cmd(1000 + i, 10 + i, 20 + i, 30 + i);
      step();
    end
    cmd_valid = 1'b0;
    check("t2_count_full", 32'(fifo_count), 32'd8);
    check("t2_ready_full", 32'(cmd_ready),  32'd0);
    check("t2_overflow",   32'(overflow),   32'd1);
    check("t2_inflight",   32'(line_x0),    32'd1000);
    cmd_clear = 1'b1;
    step();
    cmd_clear = 1'b0;
    check("t2_count_clr", 32'(fifo_count), 32'd0);
    check("t2_ovf_clr",   32'(overflow),   32'd0);
    check("t2_busy_keep", 32'(busy),       32'd1);
    repeat (3) step();
    check("t2_start_keep", 32'(line_start), 32'd1);
    line_finish = 1'b1;
    step();
    line_finish = 1'b0;
    check("t2_done", 32'(line_done),      32'd1);
    check("t2_cnt",  32'(lines_done_cnt), 32'd2);
    repeat (4) step();
    check("t2_no_dispatch", 32'(busy), 32'd0);

    // Ordering with the auto engine
    auto_eng = 1'b1; eng_delay = 4; start_run = 0;
    gap = -1; rrun = 0; prev_busy = busy; prev_reset = line_reset;
    for (int cyc = 0; cyc < 100; cyc++) begin
      if (cyc < 3) set_cmd(100 * (cyc + 1), 7, 8, 9);
      else cmd_valid = 1'b0;
      step();
      if (!busy && prev_busy) gap = 0;
      if (!busy && gap >= 0) gap++;
      if (busy && !prev_busy) begin
        disp.push_back(line_x0);
        if (gap >= 0) gaps.push_back(gap);
      end
      if (line_reset) rrun++;
      else if (prev_reset) begin rlens.push_back(rrun); rrun = 0; end
      prev_busy = busy; prev_reset = line_reset;
      if (lines_done_cnt == 16'd5) break;
    end
    cmd_valid = 1'b0;
    auto_eng = 1'b0; line_finish = 1'b0;
    check("t3_cnt",     32'(lines_done_cnt), 32'd5);
    check("t3_ndisp",   32'(disp.size()),    32'd3);
    check("t3_order0",  32'(disp[0]),        32'd100);
    check("t3_order1",  32'(disp[1]),        32'd200);
    check("t3_order2",  32'(disp[2]),        32'd300);
    check("t3_nrst",    32'(rlens.size()),   32'd3);
    for (int i = 0; i < 3; i++) check("t3_rst_len", 32'(rlens[i]), 32'd2);
    check("t3_ngaps",   32'(gaps.size()),    32'd2);
    for (int i = 0; i < 2; i++) check("t3_idle_gap", 32'(gaps[i]), 32'd1);
    step();

    // Push+pop, then push+clear
    set_cmd(400, 1, 2, 3);
    step();
    check("t4_count_a", 32'(fifo_count), 32'd1);
    set_cmd(500, 1, 2, 3);
    step();
    cmd_valid = 1'b0;
    check("t4_count_pp", 32'(fifo_count), 32'd1);
    check("t4_busy",     32'(busy),       32'd1);
    check("t4_x0",       32'(line_x0),    32'd400);
    set_cmd(999, 1, 2, 3);
    cmd_clear = 1'b1;
    step();
    cmd_valid = 1'b0; cmd_clear = 1'b0;
    check("t4_count_clr", 32'(fifo_count), 32'd0);
    check("t4_ovf",       32'(overflow),   32'd0);
    repeat (2) step();
    line_finish = 1'b1;
    step();
    line_finish = 1'b0;
    check("t4_done", 32'(line_done),      32'd1);
    check("t4_cnt",  32'(lines_done_cnt), 32'd6);
    repeat (5) step();
    check("t4_idle",   32'(busy),    32'd0);
    check("t4_x0_old", 32'(line_x0), 32'd400);

    // Stale finish held high
    line_finish = 1'b1;
    set_cmd(55, 1, 2, 3);
    step();
    set_cmd(66, 1, 2, 3);
    step();
    cmd_valid = 1'b0;
    check("t5_reset_e1", 32'(line_reset), 32'd1);
    check("t5_start_e1", 32'(line_start), 32'd0);
    check("t5_x0",       32'(line_x0),    32'd55);
    step();
    check("t5_start_e2", 32'(line_start), 32'd0);
    step();
    check("t5_start_e3", 32'(line_start), 32'd1);
    step();
    check("t5_start_e4", 32'(line_start), 32'd0);
    check("t5_done_e4",  32'(line_done),  32'd1);
    ndone = 1;
    for (int i = 0; i < 20; i++) begin
      step();
      if (line_done) ndone++;
    end
    line_finish = 1'b0;
    check("t5_ndone", 32'(ndone),          32'd2);
    check("t5_cnt",   32'(lines_done_cnt), 32'd8);
    check("t5_busy",  32'(busy),           32'd0);

    // Asynchronous reset mid-line
    set_cmd(77, 1, 2, 3); step();
    set_cmd(88, 1, 2, 3); step();
    set_cmd(99, 1, 2, 3); step();
    cmd_valid = 1'b0;
    for (int k = 0; k < 20 && !line_start; k++) step();
    check("t6_start_seen", 32'(line_start), 32'd1);
    @(posedge clk);
    #3 reset_n = 1'b0;
    #1;
    check("t6_start", 32'(line_start), 32'd0);
    check("t6_reset", 32'(line_reset), 32'd1);
    check("t6_busy",  32'(busy),       32'd0);
    check("t6_count", 32'(fifo_count), 32'd0);
    check("t6_cnt",   32'(lines_done_cnt), 32'd0);
    @(posedge clk);
    #2 reset_n = 1'b1;
    step();
    check("t6_ready",    32'(cmd_ready),  32'd1);
    check("t6_idle",     32'(busy),       32'd0);
    check("t6_reset_lo", 32'(line_reset), 32'd0);
    repeat (3) step();
    check("t6_stay_idle", 32'(busy), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/line_cmd_queue.md
Name: line_cmd_queue

Overview:
- Sits between the CPU's line-drawing I/O registers and the simple-line VGA drawing engine.
- Buffers line commands (x0, y0, x1, y1) in a FIFO so software can post several lines without polling.
- Dispatches the commands to the drawing engine one at a time: pulses the engine reset, raises start, waits for finish, then retires the command.
- Reports queue occupancy, busy state and a retired-line count back to software.

Parameters:
- COORD_W, 13, width of each coordinate.
- DEPTH, 8, FIFO entries; must be a power of two, at least 2.
- ADDR_W, 3, log2(DEPTH).
- RESET_CYCLES, 2, cycles the engine reset is held high before each line; must be at least 1.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- cmd_valid  in  1  command present on cmd_x0..cmd_y1.
- cmd_ready  out  1  FIFO can accept a command.
- cmd_x0, cmd_y0, cmd_x1, cmd_y1  in  COORD_W each  command coordinates.
- cmd_clear  in  1  flushes queued (not in-flight) commands and clears overflow.
- line_x0, line_y0, line_x1, line_y1  out  COORD_W each  coordinates to the engine.
- line_reset  out  1  engine reset.
- line_start  out  1  engine start.
- line_finish  in  1  engine done level.
- busy  out  1  a line is in flight.
- line_done  out  1  one-cycle pulse when a line retires.
- fifo_count  out  ADDR_W+1  queued entries, 0..DEPTH.
- lines_done_cnt  out  16  retired lines, wraps at 65535 to 0.
- overflow  out  1  sticky: a command was offered while the FIFO was full.

Behaviour:
- Reset (asynchronous, reset_n=0) forces:
  - all 0: FIFO pointers, fifo_count, line_x0..line_y1, line_start, busy, line_done, lines_done_cnt, overflow.
  - state = IDLE.
  - line_reset = 1, so the engine is held in reset during system reset.
  - cmd_ready = 1 as soon as reset_n returns high.
- Reset mid-line abandons that line; queued commands are lost.
- FIFO:
  - cmd_ready = (fifo_count < DEPTH), combinational from the registered count.
  - Push on any edge with cmd_valid & cmd_ready.
  - There is no write-through when full: a push into a full FIFO is never accepted, even if a pop happens in the same cycle.
  - Push and pop in the same cycle leave fifo_count unchanged.
  - Pointers wrap modulo DEPTH.
- overflow: set on any edge with cmd_valid & !cmd_ready; cleared only by cmd_clear or reset.
- cmd_clear:
  - On the edge, pointers and count go to 0 and overflow goes to 0.
  - A simultaneous push is dropped; clear wins.
  - The in-flight line is unaffected.
  - Clear and pop in the same cycle: pop data is still taken, and the count ends at 0.
- FSM states: IDLE, RST, START, (back to IDLE).
  - IDLE:
    - line_reset=0, line_start=0, busy=0.
    - If fifo_count != 0: pop the head into the line_* registers, set line_reset=1, busy=1, load the reset counter with RESET_CYCLES-1, and go to RST.
  - RST:
    - line_reset stays 1.
    - When the counter reaches 0: line_reset=0, line_start=1, go to START.
    - Otherwise decrement the counter.
    - line_reset is high for exactly RESET_CYCLES cycles.
  - START:
    - line_start held at 1.
    - On the edge where line_finish is sampled 1: line_start=0, busy=0, line_done=1 for one cycle, lines_done_cnt increments, go to IDLE.
    - line_finish is ignored in IDLE and RST, because stale finish from the previous line is cleared by the engine reset.
- line_x0..line_y1 change only on the pop edge and are stable for the whole RST/START period.
- Latency:
  - Command accepted at edge E0 into an empty queue with the FSM in IDLE.
  - Pop and line_reset=1 at E1.
  - line_start=1 at E1+RESET_CYCLES.
  - Back-to-back lines: one IDLE cycle between finish and the next pop.
- Coordinates pass through unmodified; no clipping or range checks.

Test Plan:
- Single line: reset, push (10,20,300,200) -> fifo_count 1 after E0; at E1 line_reset=1 and line_x0=10, line_y1=200; line_reset high 2 cycles, then line_start=1; assert line_finish 5 cycles later -> line_start=0, line_done pulse, lines_done_cnt=1, busy=0.
- Fill/overflow: with line_finish held 0, push 10 commands back to back -> 1 popped, 8 queued, fifo_count=8, cmd_ready=0, 10th push refused, overflow=1; cmd_clear -> fifo_count=0, overflow=0, in-flight line continues until finish.
- Ordering: queue 3 distinct commands, engine model finishes each after 4 cycles -> line_x0 sequence matches push order, each line_reset pulse is 2 cycles, lines_done_cnt=3, exactly 1 IDLE cycle between lines.
- Simultaneous push+pop and push+clear: FIFO count 1 in IDLE with push in the same cycle -> count stays 1; push with cmd_clear -> count 0, pushed data never dispatched.
- Stale finish: hold line_finish=1 continuously and push a command -> line_start still rises only after the 2-cycle reset, then retires on the first START cycle; line_done pulses once per command.
- Async reset mid-line: drop reset_n during START -> line_start=0, line_reset=1, busy=0, fifo_count=0 immediately with no clock edge; after release the FSM idles with cmd_ready=1.
